// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM ID-stage control unit: modes, opcodes,
// ALU commands, condition codes and the memory-wait FSM states.
package arm_ctrl_pkg;

  localparam logic [1:0] MODE_DATA    = 2'b00;
  localparam logic [1:0] MODE_MEM     = 2'b01;
  localparam logic [1:0] MODE_BRANCH  = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } ctrl_state_e;

  // One decoded control word as it sits in the ID/EX register.
  typedef struct packed {
    logic [3:0] cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb;
    logic       b;
    logic       s;
    logic       illegal;
  } ctrl_word_t;

endpackage

// File: rtl/arm_cond_check.sv
// ARM condition-field evaluation against the {N,Z,C,V} flags.
module arm_cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] status_i,
  output logic       pass_o
);

  logic flag_n, flag_z, flag_c, flag_v;

  assign flag_n = status_i[3];
  assign flag_z = status_i[2];
  assign flag_c = status_i[1];
  assign flag_v = status_i[0];

  // Full condition table; 1111 is treated as never-execute.
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = flag_z;
      COND_NE: pass_o = ~flag_z;
      COND_CS: pass_o = flag_c;
      COND_CC: pass_o = ~flag_c;
      COND_MI: pass_o = flag_n;
      COND_PL: pass_o = ~flag_n;
      COND_VS: pass_o = flag_v;
      COND_VC: pass_o = ~flag_v;
      COND_HI: pass_o = flag_c & ~flag_z;
      COND_LS: pass_o = ~flag_c | flag_z;
      COND_GE: pass_o = (flag_n == flag_v);
      COND_LT: pass_o = (flag_n != flag_v);
      COND_GT: pass_o = ~flag_z & (flag_n == flag_v);
      COND_LE: pass_o = flag_z | (flag_n != flag_v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_ctrl_pipe_unit.sv
// ID-stage control: decode, condition gating, ID/EX control register,
// memory-wait FSM and saturating issued-instruction counter.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | register free to load; stall_out follows hazard only
// ST_WAIT | memory op held for MEM_LAT cycles; stall_out forced high
module arm_ctrl_pipe_unit
  import arm_ctrl_pkg::*;
#(
  parameter int CMD_W   = 4,
  parameter int MEM_LAT = 1,
  parameter int COND_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [1:0]       mode,
  input  logic [3:0]       op_code,
  input  logic             s_in,
  input  logic [3:0]       cond,
  input  logic [3:0]       status,
  input  logic             hazard,
  input  logic             flush,
  output logic [CMD_W-1:0] exe_cmd,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic             wb_en,
  output logic             b,
  output logic             s,
  output logic             valid_out,
  output logic             illegal,
  output logic             stall_out,
  output logic [CNT_W-1:0] issue_cnt
);

  localparam int WCNT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam bit LAT_WAIT = (MEM_LAT > 1);

  ctrl_word_t        dec;
  ctrl_word_t        word_d, word_q;
  logic              valid_d, valid_q;
  logic              cond_pass, pass, live, load_en;
  ctrl_state_e       state_d, state_q;
  logic [WCNT_W-1:0] wcnt_d, wcnt_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  arm_cond_check u_cond (
    .cond_i   (cond),
    .status_i (status),
    .pass_o   (cond_pass)
  );

  assign pass      = (COND_EN != 0) ? cond_pass : 1'b1;
  assign live      = valid_in & pass;
  assign stall_out = hazard | (state_q == ST_WAIT);
  assign load_en   = ~flush & ~stall_out;

  // Decode mode/op_code/S into a control word; unknown encodings flag illegal.
  always_comb begin
    dec = '0;
    case (mode)
      MODE_DATA: begin
        dec.wb = 1'b1;
        dec.s  = s_in;
        case (op_code)
          OP_MOV: dec.cmd = CMD_MOV;
          OP_MVN: dec.cmd = CMD_MVN;
          OP_ADD: dec.cmd = CMD_ADD;
          OP_ADC: dec.cmd = CMD_ADC;
          OP_SUB: dec.cmd = CMD_SUB;
          OP_SBC: dec.cmd = CMD_SBC;
          OP_AND: dec.cmd = CMD_AND;
          OP_ORR: dec.cmd = CMD_ORR;
          OP_EOR: dec.cmd = CMD_EOR;
          OP_CMP: begin
            dec.cmd = CMD_SUB;
            dec.wb  = 1'b0;
            dec.s   = 1'b1;
          end
          OP_TST: begin
            dec.cmd = CMD_AND;
            dec.wb  = 1'b0;
            dec.s   = 1'b1;
          end
          default: begin
            dec         = '0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      MODE_MEM: begin
        dec.cmd       = CMD_ADD;
        dec.mem_read  = s_in;
        dec.wb        = s_in;
        dec.mem_write = ~s_in;
      end
      MODE_BRANCH: dec.b = 1'b1;
      default:     dec.illegal = 1'b1;
    endcase
  end

  // Failing condition or empty slot becomes a bubble.
  always_comb begin
    word_d  = '0;
    valid_d = 1'b0;
    if (live) begin
      word_d  = dec;
      valid_d = 1'b1;
    end
  end

  // ID/EX control register: reset > flush > stall hold > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (!stall_out) begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  // Memory-wait next state; flush aborts a wait in progress.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (flush) begin
      state_d = ST_IDLE;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (LAT_WAIT && load_en && live && (dec.mem_read | dec.mem_write)) begin
            state_d = ST_WAIT;
            wcnt_d  = WCNT_W'(MEM_LAT - 1);
          end
        end
        ST_WAIT: begin
          wcnt_d = wcnt_q - WCNT_W'(1);
          if (wcnt_q == WCNT_W'(1)) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end
      endcase
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Count live, legal loads; sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (load_en && live && !dec.illegal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Issued-instruction counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign exe_cmd      = CMD_W'(word_q.cmd);
  assign mem_read_en  = word_q.mem_read;
  assign mem_write_en = word_q.mem_write;
  assign wb_en        = word_q.wb;
  assign b            = word_q.b;
  assign s            = word_q.s;
  assign illegal      = word_q.illegal;
  assign valid_out    = valid_q;
  assign issue_cnt    = cnt_q;

endmodule

// File: tb/tb_arm_ctrl_pipe_unit.sv
// Bench for arm_ctrl_pipe_unit with MEM_LAT=3, CNT_W=2: directed scenarios
// plus randomized traffic checked against a behavioural reference model.
module tb_arm_ctrl_pipe_unit;

  localparam int CMD_W   = 4;
  localparam int MEM_LAT = 3;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, valid_in, s_in, hazard, flush;
  logic [1:0]       mode;
  logic [3:0]       op_code, cond, status;
  logic [CMD_W-1:0] exe_cmd;
  logic             mem_read_en, mem_write_en, wb_en, b, s, valid_out, illegal, stall_out;
  logic [CNT_W-1:0] issue_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [3:0] m_cmd;
  logic       m_mr, m_mw, m_wb, m_b, m_s, m_valid, m_ill;
  int         m_cnt, m_wait;

  arm_ctrl_pipe_unit #(.CMD_W(CMD_W), .MEM_LAT(MEM_LAT), .COND_EN(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mode(mode), .op_code(op_code), .s_in(s_in),
    .cond(cond), .status(status), .hazard(hazard), .flush(flush), .exe_cmd(exe_cmd),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .wb_en(wb_en), .b(b), .s(s),
    .valid_out(valid_out), .illegal(illegal), .stall_out(stall_out), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // ARM conditions: pairs share a base test, odd code inverts it.
  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] st);
    bit n, z, cf, v, base;
    n = st[3]; z = st[2]; cf = st[1]; v = st[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  // Opcode table for data-processing instructions.
  function automatic void ref_decode(input logic [1:0] md, input logic [3:0] op, input logic sb,
                                     output logic [3:0] cmd, output logic mr, output logic mw,
                                     output logic wb, output logic br, output logic sf,
                                     output logic il);
    cmd = 4'd0; mr = 0; mw = 0; wb = 0; br = 0; sf = 0; il = 0;
    if (md == 2'd0) begin
      wb = 1; sf = sb;
      case (op)
        4'hD: cmd = 4'd1;
        4'hF: cmd = 4'd9;
        4'h4: cmd = 4'd2;
        4'h5: cmd = 4'd3;
        4'h2: cmd = 4'd4;
        4'h6: cmd = 4'd5;
        4'h0: cmd = 4'd6;
        4'hC: cmd = 4'd7;
        4'h1: cmd = 4'd8;
        4'hA: begin cmd = 4'd4; wb = 0; sf = 1; end
        4'h8: begin cmd = 4'd6; wb = 0; sf = 1; end
        default: begin wb = 0; sf = 0; il = 1; end
      endcase
    end else if (md == 2'd1) begin
      cmd = 4'd2; mr = sb; wb = sb; mw = !sb;
    end else if (md == 2'd2) begin
      br = 1;
    end else begin
      il = 1;
    end
  endfunction

  task automatic model_clear();
    m_cmd = 0; m_mr = 0; m_mw = 0; m_wb = 0; m_b = 0; m_s = 0; m_valid = 0; m_ill = 0;
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_edge();
    logic [3:0] cmd;
    logic mr, mw, wb, br, sf, il;
    bit live, stall;
    stall = hazard || (m_wait > 0);
    if (rst) begin
      model_clear(); m_cnt = 0; m_wait = 0;
    end else if (flush) begin
      model_clear(); m_wait = 0;
    end else if (stall) begin
      if (m_wait > 0) m_wait--;
    end else begin
      ref_decode(mode, op_code, s_in, cmd, mr, mw, wb, br, sf, il);
      live = valid_in && ref_cond(cond, status);
      if (!live) model_clear();
      else begin
        m_cmd = cmd; m_mr = mr; m_mw = mw; m_wb = wb; m_b = br; m_s = sf;
        m_ill = il; m_valid = 1;
        if (!il && m_cnt < CNT_MAX) m_cnt++;
        if ((mr || mw) && MEM_LAT > 1) m_wait = MEM_LAT - 1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] md, input logic [3:0] op,
                       input logic sb, input logic [3:0] c);
    valid_in = v; mode = md; op_code = op; s_in = sb; cond = c;
  endtask

  task automatic test_reset();
    logic [13:0] act;
    rst = 1; hazard = 0; flush = 0; status = 0;
    drive(0, 2'd0, 4'd0, 0, 4'hE);
    tick(); tick();
    rst = 0;
    act = {exe_cmd, mem_read_en, mem_write_en, wb_en, b, s, valid_out, illegal, stall_out, issue_cnt};
    checks++;
    if (act !== 14'd0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", act, 14'd0);
    end
    hazard = 1; #1;
    checks++;
    if (stall_out !== 1'b1) begin
      failures++; $display("FAIL reset_stall_follows_hazard got=%b exp=1", stall_out);
    end
    hazard = 0; #1;
  endtask

  task automatic test_add();
    drive(1, 2'd0, 4'b0100, 1, 4'b1110);
    tick();
    checks++;
    if ({exe_cmd, wb_en, s, valid_out, issue_cnt} !== {4'b0010, 1'b1, 1'b1, 1'b1, 2'd1}) begin
      failures++;
      $display("FAIL add_decode got cmd=%b wb=%b s=%b v=%b cnt=%0d exp cmd=0010 wb=1 s=1 v=1 cnt=1",
               exe_cmd, wb_en, s, valid_out, issue_cnt);
    end
  endtask

  task automatic test_cond_fail();
    drive(1, 2'd0, 4'b0100, 1, 4'b0000);
    status = 4'b0000;
    tick();
    checks++;
    if ({valid_out, wb_en, issue_cnt} !== {1'b0, 1'b0, 2'd1}) begin
      failures++;
      $display("FAIL cond_eq_bubble got v=%b wb=%b cnt=%0d exp v=0 wb=0 cnt=1", valid_out, wb_en, issue_cnt);
    end
  endtask

  task automatic test_ldr_wait();
    logic [2:0] exp_mr;
    logic [2:0] exp_st;
    exp_mr = 3'b111;
    exp_st = 3'b110;
    drive(1, 2'd1, 4'd0, 1, 4'b1110);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) drive(0, 2'd0, 4'd0, 0, 4'b1110);
      checks++;
      if (i < 3) begin
        if ({mem_read_en, wb_en, stall_out} !== {exp_mr[2-i], exp_mr[2-i], exp_st[2-i]}) begin
          failures++;
          $display("FAIL ldr_wait_cycle%0d got mr=%b wb=%b stall=%b exp mr=1 wb=1 stall=%b",
                   i, mem_read_en, wb_en, stall_out, exp_st[2-i]);
        end
      end else if ({mem_read_en, valid_out, stall_out} !== 3'b000) begin
        failures++;
        $display("FAIL ldr_wait_release got mr=%b v=%b stall=%b exp 000", mem_read_en, valid_out, stall_out);
      end
    end
    checks++;
    if (issue_cnt !== 2'd2) begin
      failures++; $display("FAIL ldr_count got=%0d exp=2", issue_cnt);
    end
  endtask

  task automatic test_hazard();
    drive(1, 2'd0, 4'b0100, 0, 4'b1110);
    tick();
    hazard = 1;
    drive(1, 2'd0, 4'b1101, 0, 4'b1110);
    tick();
    checks++;
    if ({exe_cmd, wb_en, stall_out} !== {4'b0010, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL hazard_hold got cmd=%b wb=%b stall=%b exp cmd=0010 wb=1 stall=1", exe_cmd, wb_en, stall_out);
    end
    hazard = 0;
    tick();
    checks++;
    if ({exe_cmd, stall_out} !== {4'b0001, 1'b0}) begin
      failures++; $display("FAIL hazard_release got cmd=%b stall=%b exp cmd=0001 stall=0", exe_cmd, stall_out);
    end
  endtask

  task automatic test_flush_wait();
    drive(1, 2'd1, 4'd0, 0, 4'b1110);
    tick();
    checks++;
    if ({mem_write_en, stall_out} !== 2'b11) begin
      failures++; $display("FAIL str_enter_wait got mw=%b stall=%b exp 11", mem_write_en, stall_out);
    end
    flush = 1; hazard = 1;
    tick();
    checks++;
    if ({exe_cmd, mem_read_en, mem_write_en, wb_en, b, s, valid_out, stall_out} !== {4'd0, 7'd0, 1'b1}) begin
      failures++;
      $display("FAIL flush_in_wait got cmd=%b mw=%b v=%b stall=%b exp cmd=0000 mw=0 v=0 stall=1",
               exe_cmd, mem_write_en, valid_out, stall_out);
    end
    flush = 0; hazard = 0; valid_in = 0; #1;
    checks++;
    if (stall_out !== 1'b0) begin
      failures++; $display("FAIL flush_state_idle got stall=%b exp=0", stall_out);
    end
  endtask

  task automatic test_illegal();
    rst = 1; tick(); rst = 0;
    drive(1, 2'd3, 4'd0, 1, 4'b1110);
    tick();
    checks++;
    if ({illegal, exe_cmd, wb_en, b, mem_read_en, mem_write_en, issue_cnt} !== {1'b1, 10'd0}) begin
      failures++;
      $display("FAIL illegal_mode11 got il=%b cmd=%b wb=%b b=%b cnt=%0d exp il=1 others 0",
               illegal, exe_cmd, wb_en, b, issue_cnt);
    end
    drive(1, 2'd0, 4'b0011, 1, 4'b1110);
    tick();
    checks++;
    if ({illegal, exe_cmd, wb_en, s, issue_cnt} !== {1'b1, 8'd0}) begin
      failures++;
      $display("FAIL illegal_op0011 got il=%b cmd=%b wb=%b s=%b cnt=%0d exp il=1 others 0",
               illegal, exe_cmd, wb_en, s, issue_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int exp;
    rst = 1; tick(); rst = 0;
    drive(1, 2'd0, 4'b0100, 0, 4'b1110);
    for (int i = 0; i < 5; i++) begin
      tick();
      exp = (i + 1 > CNT_MAX) ? CNT_MAX : i + 1;
      checks++;
      if (issue_cnt !== CNT_W'(exp) || exe_cmd !== 4'b0010) begin
        failures++;
        $display("FAIL b2b_add%0d got cnt=%0d cmd=%b exp cnt=%0d cmd=0010", i, issue_cnt, exe_cmd, exp);
      end
    end
  endtask

  task automatic test_reset_wait();
    drive(1, 2'd1, 4'd0, 1, 4'b1110);
    tick();
    checks++;
    if (stall_out !== 1'b1) begin
      failures++; $display("FAIL rstwait_enter got stall=%b exp=1", stall_out);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({stall_out, mem_read_en, issue_cnt} !== 4'b0000) begin
      failures++;
      $display("FAIL rstwait_abort got stall=%b mr=%b cnt=%0d exp 0 0 0", stall_out, mem_read_en, issue_cnt);
    end
  endtask

  task automatic test_random();
    logic [13:0] act, exp;
    logic        exp_stall;
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      hazard   = ($urandom_range(0, 3) == 0);
      valid_in = ($urandom_range(0, 7) != 0);
      mode     = 2'($urandom_range(0, 3));
      op_code  = 4'($urandom_range(0, 15));
      s_in     = 1'($urandom_range(0, 1));
      cond     = ($urandom_range(0, 1) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
      status   = 4'($urandom_range(0, 15));
      tick();
      exp_stall = hazard || (m_wait > 0);
      act = {exe_cmd, mem_read_en, mem_write_en, wb_en, b, s, valid_out, illegal, stall_out, issue_cnt};
      exp = {m_cmd, m_mr, m_mw, m_wb, m_b, m_s, m_valid, m_ill, exp_stall, CNT_W'(m_cnt)};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL random_cycle%0d got=%b exp=%b (cmd,mr,mw,wb,b,s,v,il,stall,cnt)", i, act, exp);
      end
    end
    rst = 0; flush = 0; hazard = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_cond_fail();
    test_ldr_wait();
    test_hazard();
    test_flush_wait();
    test_illegal();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
